fetch_buffer: RTL

- Dual-width instruction fetch stage that sits directly upstream of the decode stage.
- Drives a 2-word-per-cycle instruction memory and queues returned words with their PCs in a circular buffer.
- Presents up to two in-order instructions per cycle to decode over a valid/ready handshake.
- Handles redirects (branch/JAL resolve) by flushing the queue and discarding in-flight fetch data.

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/fetch_buffer_if.sv | 39 +++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_buffer.sv | 96 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: opcode encodings, queue entry and the 2-slot decode bundle.
// Optional predecode flag generation is enabled with FETCH_PREDECODE_CHECK_EN.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] B_TYPE = 7'b1100011;
    localparam logic [6:0] I_IMME = 7'b0010011;
    localparam logic [6:0] R_TYPE = 7'b0110011;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
        logic                  illegal;
    } fetch_entry_t;

    typedef struct packed {
        logic [1:0]   valid;
        fetch_entry_t slot1;
        fetch_entry_t slot0;
    } fetch_out_t;

    function automatic logic opcode_illegal(input logic [6:0] opcode);
        logic bad;
        case (opcode)
            LOAD, S_TYPE, JAL, B_TYPE, I_IMME, R_TYPE: bad = 1'b0;
            default:                                   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus: instruction memory request/response, redirect and the decode handshake.
// out_illegal exists only when FETCH_PREDECODE_CHECK_EN is defined.
interface fetch_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_valid;
    logic [XLEN-1:0] imem_rdata0;
    logic [XLEN-1:0] imem_rdata1;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      out_valid;
    logic [XLEN-1:0] out_instr0;
    logic [XLEN-1:0] out_instr1;
    logic [XLEN-1:0] out_pc0;
    logic [XLEN-1:0] out_pc1;
    logic            dec_ready;
`ifdef FETCH_PREDECODE_CHECK_EN
    logic [1:0]      out_illegal;
`endif

    modport master (
`ifdef FETCH_PREDECODE_CHECK_EN
        output out_illegal,
`endif
        output imem_req, imem_addr, out_valid, out_instr0, out_instr1, out_pc0, out_pc1,
        input  imem_valid, imem_rdata0, imem_rdata1, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
`ifdef FETCH_PREDECODE_CHECK_EN
        input  out_illegal,
`endif
        input  imem_req, imem_addr, out_valid, out_instr0, out_instr1, out_pc0, out_pc1,
        output imem_valid, imem_rdata0, imem_rdata1, redirect_valid, redirect_pc, dec_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer accepting two entries per push and releasing 0-2 entries per cycle, with flush.
// Slots are presented combinationally from the head; invalid slots read as zero.
module fetch_fifo #(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = fetch_pkg::fetch_entry_t,
    localparam int unsigned IdxW   = $clog2(DEPTH),
    localparam int unsigned CntW   = IdxW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  entry_t          push_data0,
    input  entry_t          push_data1,
    input  logic [1:0]      pop_cnt,
    output logic [1:0]      out_valid,
    output entry_t          out_slot0,
    output entry_t          out_slot1,
    output logic [CntW-1:0] count
);
    entry_t            mem_q [DEPTH];
    logic [IdxW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q + IdxW'(pop_cnt);
        tail_d  = push ? tail_q + IdxW'(2) : tail_q;
        count_d = count_q + (push ? CntW'(2) : CntW'(0)) - CntW'(pop_cnt);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q]              <= push_data0;
                mem_q[tail_q + IdxW'(1)]   <= push_data1;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        out_valid = {count_q >= CntW'(2), count_q >= CntW'(1)};
        out_slot0 = out_valid[0] ? mem_q[head_q] : '0;
        out_slot1 = out_valid[1] ? mem_q[head_q + IdxW'(1)] : '0;
        count     = count_q;
    end

endmodule

// File: rtl/fetch_buffer.sv
// Dual-width fetch stage: owns PC, in-flight flag and request throttling; queues into fetch_fifo.
// Define FETCH_PREDECODE_CHECK_EN to add per-slot illegal-opcode flags.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 8,
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int unsigned    CntW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    fetch_buffer_if.master bus
);
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            req, push;
    logic [1:0]      pop_cnt;
    logic [CntW-1:0] count;
    fetch_entry_t    push0, push1;
    fetch_out_t      out;

    // Space is reserved for the in-flight pair and the new one; pops are not credited.
    always_comb begin
        req        = !bus.redirect_valid &&
                     (32'(count) + (inflight_q ? 32'd2 : 32'd0) + 32'd2 <= 32'(DEPTH));
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = req;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (req) begin
            pc_d     = pc_q + XLEN'(8);
            req_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        push          = bus.imem_valid && inflight_q && !bus.redirect_valid;
        push0.instr   = bus.imem_rdata0;
        push0.pc      = req_pc_q;
        push1.instr   = bus.imem_rdata1;
        push1.pc      = req_pc_q + XLEN'(4);
`ifdef FETCH_PREDECODE_CHECK_EN
        push0.illegal = opcode_illegal(bus.imem_rdata0[6:0]);
        push1.illegal = opcode_illegal(bus.imem_rdata1[6:0]);
`else
        push0.illegal = 1'b0;
        push1.illegal = 1'b0;
`endif
        pop_cnt = bus.dec_ready ? 2'(out.valid[0]) + 2'(out.valid[1]) : 2'd0;
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.redirect_valid),
        .push       (push),
        .push_data0 (push0),
        .push_data1 (push1),
        .pop_cnt    (pop_cnt),
        .out_valid  (out.valid),
        .out_slot0  (out.slot0),
        .out_slot1  (out.slot1),
        .count      (count)
    );

    always_comb begin
        bus.imem_req   = req;
        bus.imem_addr  = pc_q;
        bus.out_valid  = out.valid;
        bus.out_instr0 = out.slot0.instr;
        bus.out_instr1 = out.slot1.instr;
        bus.out_pc0    = out.slot0.pc;
        bus.out_pc1    = out.slot1.pc;
`ifdef FETCH_PREDECODE_CHECK_EN
        bus.out_illegal = {out.slot1.illegal, out.slot0.illegal};
`endif
    end

endmodule
